// File: rtl/canny_seq_pkg.sv
// Shared types and defaults for the Canny frame sequencer and its position counters.
package canny_seq_pkg;

   localparam int PIX_W     = 8;
   localparam int IMG_W_DEF = 512;
   localparam int IMG_H_DEF = 512;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_t;

endpackage

// File: rtl/canny_xy_counter.sv
// Column/row position counter: column wraps at W-1, row saturates at H-1,
// term flags the last pixel position of the frame.
module canny_xy_counter #(
   parameter int W = 8,
   parameter int H = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 inc,
   output logic [$clog2(W)-1:0] col,
   output logic [$clog2(H)-1:0] row,
   output logic                 term
);

   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);

   logic col_wrap;
   logic row_last;

   assign col_wrap = (col == CW'(W - 1));
   assign row_last = (row == RW'(H - 1));
   assign term     = col_wrap && row_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (clr) begin
         col <= '0;
         row <= '0;
      end else if (inc) begin
         if (col_wrap) begin
            col <= '0;
            if (!row_last) row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/canny_frame_sequencer.sv
// Frame sequencer around the Canny edge datapath: streams one frame in, drains the
// datapath with zero pixels, and forwards exactly IMG_W*IMG_H results with their position.
// Optional watchdog is compiled in with CANNY_SEQ_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | accepting source pixels into the datapath
// FLUSH  | feeding zeros until all results are out or FLUSH_MAX cycles pass
// DONE   | one-cycle completion pulse
module canny_frame_sequencer
   import canny_seq_pkg::*;
#(
   parameter int IMG_W     = IMG_W_DEF,
   parameter int IMG_H     = IMG_H_DEF,
   parameter int FLUSH_MAX = 2*IMG_W + 16,
   parameter int WDOG_CYC  = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   input  logic [PIX_W-1:0]         s_pixel,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [PIX_W-1:0]         dp_pixel,
   output logic                     dp_valid,
   input  logic [PIX_W-1:0]         dp_out_pixel,
   input  logic                     dp_out_valid,
   output logic [PIX_W-1:0]         m_pixel,
   output logic                     m_valid,
   output logic [$clog2(IMG_H)-1:0] out_row,
   output logic [$clog2(IMG_W)-1:0] out_col
);

   localparam int FW = $clog2(FLUSH_MAX + 1);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   seq_state_t state, state_next;

   logic          frame_go;
   logic          xfer;
   logic          accept;
   logic          in_term;
   logic          out_term;
   logic          out_full;
   logic          flush_hit;
   logic          wdog_hit;
   logic [FW-1:0] flush_cnt;
   logic [CW-1:0] in_col, oc_col;
   logic [RW-1:0] in_row, oc_row;
   logic          unused_in_pos;

   assign frame_go  = (state == ST_IDLE) && start;
   assign xfer      = (state == ST_STREAM) && s_valid;
   // Results are only taken while a frame is active and the quota is not yet met.
   assign accept    = ((state == ST_STREAM) || (state == ST_FLUSH)) && dp_out_valid && !out_full;
   assign flush_hit = (flush_cnt == FW'(FLUSH_MAX - 1));

   assign unused_in_pos = ^{in_col, in_row};

   canny_xy_counter #(.W(IMG_W), .H(IMG_H)) u_in_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (frame_go),
      .inc  (xfer),
      .col  (in_col),
      .row  (in_row),
      .term (in_term)
   );

   canny_xy_counter #(.W(IMG_W), .H(IMG_H)) u_out_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (frame_go),
      .inc  (accept),
      .col  (oc_col),
      .row  (oc_row),
      .term (out_term)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (start) state_next = ST_STREAM;
         ST_STREAM: begin
            if (wdog_hit)              state_next = ST_DONE;
            else if (xfer && in_term)  state_next = ST_FLUSH;
         end
         ST_FLUSH:  if (wdog_hit || out_full || flush_hit) state_next = ST_DONE;
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready = (state == ST_STREAM);
      busy    = (state == ST_STREAM) || (state == ST_FLUSH);
      done    = (state == ST_DONE);
   end

   // Zero padding stops on the last FLUSH cycle so nothing leaks into DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_pixel <= '0;
         dp_valid <= 1'b0;
      end else if (xfer) begin
         dp_pixel <= s_pixel;
         dp_valid <= 1'b1;
      end else begin
         dp_pixel <= '0;
         dp_valid <= (state == ST_FLUSH) && (state_next == ST_FLUSH);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    flush_cnt <= '0;
      else if (frame_go)          flush_cnt <= '0;
      else if (state == ST_FLUSH) flush_cnt <= flush_cnt + 1'b1;
   end

   // out_row/out_col capture the position of the result being forwarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pixel  <= '0;
         m_valid  <= 1'b0;
         out_row  <= '0;
         out_col  <= '0;
         out_full <= 1'b0;
      end else if (frame_go) begin
         m_pixel  <= '0;
         m_valid  <= 1'b0;
         out_row  <= '0;
         out_col  <= '0;
         out_full <= 1'b0;
      end else begin
         m_valid <= accept;
         m_pixel <= accept ? dp_out_pixel : '0;
         if (accept) begin
            out_col <= oc_col;
            out_row <= oc_row;
            if (out_term) out_full <= 1'b1;
         end
      end
   end

`ifdef CANNY_SEQ_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);

   logic [WW-1:0] wdog_cnt;
   logic          quiet;

   assign quiet    = busy && !m_valid && !xfer;
   assign wdog_hit = quiet && (wdog_cnt == WW'(WDOG_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_cnt <= '0;
         error    <= 1'b0;
      end else begin
         if (frame_go)      error <= 1'b0;
         else if (wdog_hit) error <= 1'b1;
         if (quiet) wdog_cnt <= wdog_cnt + 1'b1;
         else       wdog_cnt <= '0;
      end
   end
`else
   assign wdog_hit = 1'b0;
   assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Bench for canny_frame_sequencer with an 8x4 frame and a 10-cycle datapath model.
module tb_canny_frame_sequencer;

   localparam int W   = 8;
   localparam int H   = 4;
   localparam int N   = W * H;
   localparam int DLY = 10;

   logic       clk = 1'b0;
   logic       rst, start, s_valid, s_ready, busy, done, error;
   logic [7:0] s_pixel, dp_pixel, dp_out_pixel, m_pixel;
   logic       dp_valid, dp_out_valid, m_valid;
   logic [1:0] out_row;
   logic [2:0] out_col;

   always #5 clk = ~clk;

   canny_frame_sequencer #(.IMG_W(W), .IMG_H(H), .FLUSH_MAX(32), .WDOG_CYC(64)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
      .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
      .dp_pixel(dp_pixel), .dp_valid(dp_valid),
      .dp_out_pixel(dp_out_pixel), .dp_out_valid(dp_out_valid),
      .m_pixel(m_pixel), .m_valid(m_valid), .out_row(out_row), .out_col(out_col)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Datapath model: fixed delay, result = pixel + 100, capped emission count per frame.
   int         emit_limit = 1000;
   int         emitted = 0;
   logic       pv [0:DLY];
   logic [7:0] pp [0:DLY];

   initial begin
      dp_out_valid = 1'b0;
      dp_out_pixel = 8'd0;
      for (int k = 0; k <= DLY; k++) begin pv[k] = 1'b0; pp[k] = 8'd0; end
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            for (int k = 0; k <= DLY; k++) begin pv[k] = 1'b0; pp[k] = 8'd0; end
            emitted = 0;
            dp_out_valid = 1'b0;
            dp_out_pixel = 8'd0;
         end else begin
            for (int k = DLY; k > 0; k--) begin pv[k] = pv[k-1]; pp[k] = pp[k-1]; end
            pv[0] = dp_valid;
            pp[0] = dp_pixel;
            if (pv[DLY] && emitted < emit_limit) begin
               dp_out_valid = 1'b1;
               dp_out_pixel = 8'(pp[DLY] + 8'd100);
               emitted++;
            end else begin
               dp_out_valid = 1'b0;
               dp_out_pixel = 8'd0;
            end
         end
      end
   end

   // Reference: results are the source pixels (then flush zeros) in order, +100;
   // only the first N datapath results of a frame are forwarded, one cycle after they appear.
   int         in_cnt = 0, out_cnt = 0, mv_cnt = 0, done_cnt = 0, flush_cyc = 0, busy_cyc = 0;
   int         last_col = 0, last_row = 0, first_mpix = 0, last_mpix = 0, err_at_done = 0;
   int         expv;
   logic       p_emit = 1'b0, p_xfer = 1'b0, p_gap = 1'b0, p_done = 1'b0;
   logic [7:0] p_spix = 8'd0;
   logic [7:0] src_q [$];

   always @(negedge clk) begin
      if (rst) begin
         check("rst_outputs_quiet", int'({m_valid, dp_valid, busy, done, s_ready}), 0);
         src_q.delete();
         in_cnt = 0; out_cnt = 0;
         p_emit = 1'b0; p_xfer = 1'b0; p_gap = 1'b0; p_done = 1'b0;
      end else begin
         if (p_emit && out_cnt < N) begin
            check("m_valid_expected", int'(m_valid), 1);
            expv = (src_q.size() > 0) ? int'(8'(src_q.pop_front() + 8'd100)) : 100;
            check("m_pixel", int'(m_pixel), expv);
            check("out_col", int'(out_col), out_cnt % W);
            check("out_row", int'(out_row), out_cnt / W);
            out_cnt++;
         end else begin
            check("m_valid_unexpected", int'(m_valid), 0);
         end
         if (p_xfer) begin
            check("dp_valid_after_xfer", int'(dp_valid), 1);
            check("dp_pixel", int'(dp_pixel), int'(p_spix));
         end else if (p_gap) begin
            check("dp_valid_gap", int'(dp_valid), 0);
         end
         if (in_cnt >= N) check("s_ready_after_last", int'(s_ready), 0);
         if (m_valid) begin
            if (mv_cnt == 0) first_mpix = int'(m_pixel);
            last_mpix = int'(m_pixel);
            last_col  = int'(out_col);
            last_row  = int'(out_row);
            mv_cnt++;
         end
         if (done) begin
            check("done_single_cycle", int'(p_done), 0);
            done_cnt++;
            err_at_done = int'(error);
         end
         if (busy) busy_cyc++;
         if (busy && !s_ready) flush_cyc++;
         p_xfer = s_valid && s_ready;
         p_gap  = s_ready && !s_valid;
         p_spix = s_pixel;
         if (p_xfer) begin src_q.push_back(s_pixel); in_cnt++; end
         p_emit = dp_out_valid;
         p_done = done;
      end
   end

   task automatic start_frame(input int limit);
      @(posedge clk); #2;
      emit_limit = limit; emitted = 0;
      in_cnt = 0; out_cnt = 0; mv_cnt = 0; done_cnt = 0; flush_cyc = 0; busy_cyc = 0;
      src_q.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("error_clear_on_start", int'(error), 0);
      check("busy_after_start", int'(busy), 1);
   endtask

   task automatic drive_pixels(input int gap_mode, input int stop_at);
      int i = 0;
      int cyc = 0;
      while (i < N && cyc < 200 && i != stop_at) begin
         if (gap_mode != 0 && (cyc % 2) == 1) s_valid = 1'b0;
         else begin s_valid = 1'b1; s_pixel = 8'(i); end
         @(posedge clk); #1;
         if (s_valid) i++;
         cyc++;
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (done_cnt == 0 && c < budget) begin @(posedge clk); c++; end
      check("done_within_budget", int'(done_cnt > 0), 1);
      repeat (30) @(posedge clk);
      #1;
   endtask

   task automatic frame_checks(input string tag, input int exp_mv, input int exp_flush);
      check({tag, "_m_valid_count"}, mv_cnt, exp_mv);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_flush_cycles"}, flush_cyc, exp_flush);
      check({tag, "_busy_after"}, int'(busy), 0);
      check({tag, "_error_at_done"}, err_at_done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_pixel = 8'd0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      check("reset_state", int'({s_ready, busy, done, error, dp_valid, m_valid}), 0);
      check("reset_pos", int'({out_row, out_col}), 0);

      // back-to-back frame
      start_frame(1000);
      drive_pixels(0, -1);
      wait_done(200);
      frame_checks("b2b", 32, 12);
      check("b2b_first_m_pixel", first_mpix, 100);
      check("b2b_last_m_pixel", last_mpix, 131);
      check("b2b_last_col", last_col, 7);
      check("b2b_last_row", last_row, 3);

      // source valid on alternate cycles
      start_frame(1000);
      drive_pixels(1, -1);
      wait_done(300);
      frame_checks("alt", 32, 12);
      check("alt_last_col", last_col, 7);
      check("alt_last_row", last_row, 3);

      // datapath over-produces
      start_frame(40);
      drive_pixels(0, -1);
      wait_done(200);
      frame_checks("over", 32, 12);

      // datapath under-produces: FLUSH_MAX ends the frame
      start_frame(20);
      drive_pixels(0, -1);
      wait_done(200);
      frame_checks("under", 20, 32);

      // reset mid-frame at input pixel 15
      start_frame(1000);
      drive_pixels(0, 15);
      #2 rst = 1'b1;
      #1;
      check("midrst_ctrl", int'({s_ready, busy, done, error, dp_valid, m_valid}), 0);
      check("midrst_dp_pixel", int'(dp_pixel), 0);
      check("midrst_m_pixel", int'(m_pixel), 0);
      check("midrst_pos", int'({out_row, out_col}), 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_no_done", done_cnt, 0);
      check("midrst_idle", int'(busy), 0);
      start_frame(1000);
      drive_pixels(0, -1);
      wait_done(200);
      frame_checks("after_rst", 32, 12);
      check("after_rst_last_m_pixel", last_mpix, 131);

`ifdef CANNY_SEQ_WATCHDOG_EN
      start_frame(1000);
      wait_done(150);
      check("wdog_error_at_done", err_at_done, 1);
      check("wdog_busy_cycles", busy_cyc, 64);
      check("wdog_done_count", done_cnt, 1);
      check("wdog_error_sticky", int'(error), 1);
      start_frame(1000);
      drive_pixels(0, -1);
      wait_done(200);
      frame_checks("post_wdog", 32, 12);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
